steer_en_ctrl: RTL and testbench

STEER_EN_CTRL -- requirements
Module: steer_en_ctrl

---
 rtl/steer_en_ctrl.sv | 120 ++++++++++++
 tb/tb_steer_en_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/steer_en_ctrl.sv
// steer_en_ctrl: steering-enable controller for a self-balancing platform.
// Steering is enabled only after a rider is present and balanced for the
// settle time. Weight hysteresis keeps rider detection from chattering.
module steer_en_ctrl #(
   parameter int unsigned FAST_SIM      = 0,
   parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
   parameter logic [11:0] WT_HYSTERESIS = 12'h040
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] lft_ld,
   input  logic [11:0] rght_ld,
   output logic        en_steer,
   output logic        rider_off
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      STEER = 2'd2
   } state_t;

   localparam logic [11:0] OFF_WT_12 = MIN_RIDER_WT - WT_HYSTERESIS;
   localparam logic [12:0] MIN_WT    = {1'b0, MIN_RIDER_WT};
   localparam logic [12:0] OFF_WT    = {1'b0, OFF_WT_12};

   state_t             state_q, state_d;
   logic        [25:0] timer_q, timer_d;
   logic               en_steer_q, en_steer_d;
   logic               rider_off_q, rider_off_d;

   logic        [12:0] sum;
   logic signed [12:0] diff_s;
   logic signed [12:0] diff_neg;
   logic        [11:0] diff_abs;
   logic        [12:0] sum_qtr;
   logic        [12:0] sum_15_16;
   logic               sum_gt_min, sum_lt_min;
   logic               diff_gt_1_4, diff_gt_15_16;
   logic               tmr_full, clr_tmr;

   // Load sum, absolute imbalance and the threshold compares
   always_comb begin
      sum           = {1'b0, lft_ld} + {1'b0, rght_ld};
      diff_s        = $signed({1'b0, lft_ld}) - $signed({1'b0, rght_ld});
      diff_neg      = -diff_s;
      diff_abs      = diff_s[12] ? diff_neg[11:0] : diff_s[11:0];
      sum_qtr       = sum >> 2;
      sum_15_16     = sum - (sum >> 4);
      sum_gt_min    = (sum > MIN_WT);
      sum_lt_min    = (sum < OFF_WT);
      diff_gt_1_4   = ({1'b0, diff_abs} > sum_qtr);
      diff_gt_15_16 = ({1'b0, diff_abs} > sum_15_16);
      tmr_full      = (FAST_SIM != 0) ? (timer_q[14:0] == '1) : (timer_q == '1);
   end

   // Next state, timer clear/increment and next registered outputs
   always_comb begin
      state_d = state_q;
      clr_tmr = 1'b0;
      case (state_q)
         IDLE: begin
            if (sum_gt_min) begin
               state_d = WAIT;
               clr_tmr = 1'b1;
            end
         end
         WAIT: begin
            if (sum_lt_min) begin
               state_d = IDLE;
            end else if (diff_gt_1_4) begin
               clr_tmr = 1'b1;
            end else if (tmr_full) begin
               state_d = STEER;
            end
         end
         STEER: begin
            if (sum_lt_min) begin
               state_d = IDLE;
            end else if (diff_gt_15_16) begin
               state_d = WAIT;
               clr_tmr = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (clr_tmr) begin
         timer_d = '0;
      end else if (state_q == WAIT) begin
         timer_d = timer_q + 26'd1;
      end else begin
         timer_d = timer_q;
      end

      // Outputs are registered from the next state so they track the
      // state register exactly while coming straight off flops.
      en_steer_d  = (state_d == STEER);
      rider_off_d = (state_d == IDLE);
   end

   // State, timer and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         en_steer_q  <= 1'b0;
         rider_off_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         en_steer_q  <= en_steer_d;
         rider_off_q <= rider_off_d;
      end
   end

   assign en_steer  = en_steer_q;
   assign rider_off = rider_off_q;

endmodule

// File: tb/tb_steer_en_ctrl.sv
// tb_steer_en_ctrl: two FAST_SIM instances run directed scenarios in parallel
// (sharing the long settle waits), then randomized loads; every cycle both
// are compared against a behavioural rider/balance model.
module tb_steer_en_ctrl;

   localparam int MIN_WT = 12'h200;
   localparam int OFF_WT = 12'h200 - 12'h040;
   localparam int SETTLE = 32768;
   localparam int M_IDLE  = 0;
   localparam int M_WAIT  = 1;
   localparam int M_STEER = 2;

   logic        clk = 1'b0;
   logic        rstn_a, rstn_b;
   logic [11:0] la, ra, lb, rb;
   logic        es_a, ro_a, es_b, ro_b;

   int n_chk = 0;
   int n_err = 0;
   bit chk_on = 1'b0;
   bit done_a = 1'b0;
   bit done_b = 1'b0;

   int m_mode   [2] = '{M_IDLE, M_IDLE};
   int m_settle [2] = '{0, 0};

   always #5 clk = ~clk;

   steer_en_ctrl #(.FAST_SIM(1), .MIN_RIDER_WT(12'h200), .WT_HYSTERESIS(12'h040)) dut_a (
      .clk(clk), .rst_n(rstn_a), .lft_ld(la), .rght_ld(ra),
      .en_steer(es_a), .rider_off(ro_a)
   );

   steer_en_ctrl #(.FAST_SIM(1), .MIN_RIDER_WT(12'h200), .WT_HYSTERESIS(12'h040)) dut_b (
      .clk(clk), .rst_n(rstn_b), .lft_ld(lb), .rght_ld(rb),
      .en_steer(es_b), .rider_off(ro_b)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int es_of(input int side);
      return (side == 0) ? int'(es_a) : int'(es_b);
   endfunction

   function automatic int ro_of(input int side);
      return (side == 0) ? int'(ro_a) : int'(ro_b);
   endfunction

   task automatic drive(input int side, input int l, input int r, input bit rn);
      if (side == 0) begin
         la = 12'(l); ra = 12'(r); rstn_a = rn;
      end else begin
         lb = 12'(l); rb = 12'(r); rstn_b = rn;
      end
   endtask

   // Reference: rider on above MIN, off below MIN-HYST; balanced cycles
   // counted in WAIT; steer after SETTLE consecutive balanced cycles.
   task automatic model_step(input int k, input int l, input int r, input bit rn);
      int sum, diff;
      sum  = l + r;
      diff = (l > r) ? l - r : r - l;
      if (!rn) begin
         m_mode[k]   = M_IDLE;
         m_settle[k] = 0;
      end else begin
         case (m_mode[k])
            M_IDLE: begin
               if (sum > MIN_WT) begin
                  m_mode[k]   = M_WAIT;
                  m_settle[k] = 0;
               end
            end
            M_WAIT: begin
               if (sum < OFF_WT)                  m_mode[k] = M_IDLE;
               else if (diff > sum / 4)           m_settle[k] = 0;
               else if (m_settle[k] == SETTLE - 1) m_mode[k] = M_STEER;
               else                               m_settle[k]++;
            end
            default: begin
               if (sum < OFF_WT) begin
                  m_mode[k] = M_IDLE;
               end else if (diff > sum - sum / 16) begin
                  m_mode[k]   = M_WAIT;
                  m_settle[k] = 0;
               end
            end
         endcase
      end
   endtask

   // Advance the reference on the same edge the DUTs see
   always @(posedge clk) begin
      model_step(0, int'(la), int'(ra), rstn_a);
      model_step(1, int'(lb), int'(rb), rstn_b);
   end

   // Every-cycle comparison against the reference, away from the clock edge
   always @(negedge clk) begin
      if (chk_on) begin
         check("a_en_steer",  int'(es_a), int'(m_mode[0] == M_STEER));
         check("a_rider_off", int'(ro_a), int'(m_mode[0] == M_IDLE));
         check("b_en_steer",  int'(es_b), int'(m_mode[1] == M_STEER));
         check("b_rider_off", int'(ro_b), int'(m_mode[1] == M_IDLE));
      end
   end

   task automatic expect_steer_after(input int side, input int edges, input string tag);
      repeat (edges - 1) @(negedge clk);
      check({tag, "_early"}, es_of(side), 0);
      @(negedge clk);
      check({tag, "_on"}, es_of(side), 1);
      check({tag, "_ro"}, ro_of(side), 0);
   endtask

   task automatic random_phase(input int side, input int n);
      int l = 0;
      int r = 0;
      int hold = 0;
      bit rn;
      for (int i = 0; i < n; i++) begin
         if (hold == 0) begin
            case ($urandom_range(0, 2))
               0: begin
                  l = int'($urandom_range(12'h0C0, 12'h130));
                  r = int'($urandom_range(12'h0C0, 12'h130));
               end
               1: begin
                  l = int'($urandom_range(0, 12'h300));
                  r = int'($urandom_range(0, 12'h300));
               end
               default: begin
                  l = int'($urandom_range(0, 12'hFFF));
                  r = int'($urandom_range(0, 12'hFFF));
               end
            endcase
            hold = int'($urandom_range(1, 12));
         end
         hold--;
         rn = ($urandom_range(0, 63) != 0);
         drive(side, l, r, rn);
         @(negedge clk);
      end
   endtask

   // Instance A: idle, threshold edge, imbalance at WAIT cycle 20000, STEER hysteresis
   initial begin : seq_a
      drive(0, 0, 0, 1'b0);
      repeat (3) @(negedge clk);
      drive(0, 0, 0, 1'b1);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         check("a_idle_ro", ro_of(0), 1);
         check("a_idle_es", es_of(0), 0);
      end
      drive(0, 12'h100, 12'h100, 1'b1);
      repeat (20) @(negedge clk);
      check("a_sum_eq_min_idle", ro_of(0), 1);
      drive(0, 12'h180, 12'h180, 1'b1);
      @(negedge clk);
      check("a_wait_entry_ro", ro_of(0), 0);
      check("a_wait_entry_es", es_of(0), 0);
      repeat (19999) @(negedge clk);
      drive(0, 12'h280, 12'h080, 1'b1);
      repeat (16) @(negedge clk);
      check("a_imbal_ro", ro_of(0), 0);
      check("a_imbal_es", es_of(0), 0);
      // diff exactly a quarter of the sum is still balanced
      drive(0, 12'h1E0, 12'h120, 1'b1);
      expect_steer_after(0, SETTLE, "a_settle");
      // diff exactly sum-sum/16 keeps STEER
      drive(0, 12'h2E8, 12'h018, 1'b1);
      repeat (10) @(negedge clk);
      check("a_diff_eq_15_16", es_of(0), 1);
      drive(0, 12'h0E0, 12'h0E0, 1'b1);
      repeat (10) @(negedge clk);
      check("a_sum_eq_off", es_of(0), 1);
      drive(0, 12'h0E8, 12'h0E8, 1'b1);
      repeat (50) @(negedge clk);
      check("a_hyst_steer", es_of(0), 1);
      drive(0, 12'h0D8, 12'h0D8, 1'b1);
      @(negedge clk);
      check("a_off_ro", ro_of(0), 1);
      check("a_off_es", es_of(0), 0);
      random_phase(0, 12000);
      done_a = 1'b1;
   end

   // Instance B: settle from entry, reset in STEER, re-settle, large diff, priority
   initial begin : seq_b
      drive(1, 0, 0, 1'b0);
      repeat (3) @(negedge clk);
      check("b_reset_ro", ro_of(1), 1);
      check("b_reset_es", es_of(1), 0);
      drive(1, 0, 0, 1'b1);
      repeat (10) @(negedge clk);
      drive(1, 12'h180, 12'h180, 1'b1);
      @(negedge clk);
      check("b_wait_entry_ro", ro_of(1), 0);
      check("b_wait_entry_es", es_of(1), 0);
      expect_steer_after(1, SETTLE, "b_settle");
      drive(1, 12'h180, 12'h180, 1'b0);
      @(negedge clk);
      check("b_rst_ro", ro_of(1), 1);
      check("b_rst_es", es_of(1), 0);
      drive(1, 12'h180, 12'h180, 1'b1);
      @(negedge clk);
      check("b_reentry_ro", ro_of(1), 0);
      expect_steer_after(1, SETTLE, "b_resettle");
      drive(1, 12'h300, 12'h000, 1'b1);
      @(negedge clk);
      check("b_diff_15_16_es", es_of(1), 0);
      check("b_diff_15_16_ro", ro_of(1), 0);
      drive(1, 12'h100, 12'h000, 1'b1);
      @(negedge clk);
      check("b_lt_min_priority", ro_of(1), 1);
      random_phase(1, 2000);
      done_b = 1'b1;
   end

   initial begin : main
      bit all_done;
      @(negedge clk);
      chk_on = 1'b1;
      all_done = 1'b0;
      for (int c = 0; c < 80000 && !all_done; c++) begin
         @(negedge clk);
         all_done = done_a && done_b;
      end
      check("all_done", int'(all_done), 1);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
